kd_tree_search_pipe: RTL and testbench

- Parametrised, fully pipelined KD-tree internal-node search engine; successor to the fixed 6-level/5-dim internal node tree.
- Holds 2^LEVELS-1 node configs (split dimension, signed median) in heap order, loaded sequentially over a config port.
- Routes one query patch per cycle to a leaf index with a valid/ready handshake, full-pipeline backpressure and a tag passthrough.
- Sits between the patch sender and the leaf-bucket/distance stage.

---
 rtl/kd_tree_search_pipe_pkg.sv | 40 ++++
 rtl/kd_tree_search_pipe_stage.sv | 67 ++++++
 rtl/kd_tree_search_pipe.sv | 139 +++++++++++++
 tb/tb_kd_tree_search_pipe.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kd_tree_search_pipe_pkg.sv
// Shared widths, node record and helpers for the KD-tree search pipeline.
// The top-level parameters default to these values and must stay equal to them.
package kd_search_pkg;

  localparam int KD_DIM_WIDTH = 11;
  localparam int KD_NUM_DIMS  = 5;
  localparam int KD_IDX_WIDTH = 3;
  localparam int KD_LEVELS    = 6;
  localparam int KD_TAG_WIDTH = 8;

  localparam int CFG_WIDTH   = 2 * KD_DIM_WIDTH;
  localparam int PATCH_WIDTH = KD_NUM_DIMS * KD_DIM_WIDTH;
  localparam int NUM_NODES   = (1 << KD_LEVELS) - 1;
  localparam int NODE_WIDTH  = KD_DIM_WIDTH + KD_IDX_WIDTH;

  typedef struct packed {
    logic signed [KD_DIM_WIDTH-1:0] median;
    logic [KD_IDX_WIDTH-1:0]        idx;
  } node_t;

  function automatic int node_base(input int level);
    return (1 << level) - 1;
  endfunction

  // Out-of-range split dimensions read as zero.
  function automatic logic signed [KD_DIM_WIDTH-1:0] slice_dim(
    input logic [PATCH_WIDTH-1:0]  patch,
    input logic [KD_IDX_WIDTH-1:0] idx
  );
    slice_dim = '0;
    for (int d = 0; d < KD_NUM_DIMS; d++) begin
      if (idx == KD_IDX_WIDTH'(d)) slice_dim = patch[d*KD_DIM_WIDTH +: KD_DIM_WIDTH];
    end
  endfunction

  function automatic logic idx_bad(input logic [KD_IDX_WIDTH-1:0] idx);
    return int'(idx) >= KD_NUM_DIMS;
  endfunction

endpackage

// File: rtl/kd_tree_search_pipe_stage.sv
// One tree level: pick this level's node from the running path, compare the
// selected patch component against the median, and register the extended path.
module kd_search_stage
  import kd_search_pkg::*;
#(
  parameter int LEVEL = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               stall_i,
  input  logic [NUM_NODES*NODE_WIDTH-1:0]    nodes_i,
  input  logic                               valid_i,
  input  logic [PATCH_WIDTH-1:0]             patch_i,
  input  logic [KD_TAG_WIDTH-1:0]            tag_i,
  input  logic [KD_LEVELS-1:0]               path_i,
  output logic                               valid_o,
  output logic [PATCH_WIDTH-1:0]             patch_o,
  output logic [KD_TAG_WIDTH-1:0]            tag_o,
  output logic [KD_LEVELS-1:0]               path_o,
  output logic                               bad_o
);

  localparam logic [KD_LEVELS-1:0] PATH_MASK = KD_LEVELS'((1 << LEVEL) - 1);
  localparam logic [KD_LEVELS-1:0] BASE      = KD_LEVELS'(node_base(LEVEL));

  logic [KD_LEVELS-1:0]           adr;
  node_t                          node;
  logic signed [KD_DIM_WIDTH-1:0] slice;
  logic                           go_right;
  logic [KD_LEVELS-1:0]           path_d;
  logic                           unused_path_msb;

  logic                           valid_q;
  logic [PATCH_WIDTH-1:0]         patch_q;
  logic [KD_TAG_WIDTH-1:0]        tag_q;
  logic [KD_LEVELS-1:0]           path_q;

  // Only the low LEVEL bits of the incoming path are meaningful here.
  assign adr      = BASE + (path_i & PATH_MASK);
  assign node     = nodes_i[adr*NODE_WIDTH +: NODE_WIDTH];
  assign slice    = slice_dim(patch_i, node.idx);
  assign go_right = !(slice < node.median);
  assign path_d   = {path_i[KD_LEVELS-2:0], go_right};
  assign bad_o    = valid_i && idx_bad(node.idx);

  assign unused_path_msb = path_i[KD_LEVELS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      patch_q <= '0;
      tag_q   <= '0;
      path_q  <= '0;
    end else if (!stall_i) begin
      valid_q <= valid_i;
      patch_q <= patch_i;
      tag_q   <= tag_i;
      path_q  <= path_d;
    end
  end

  assign valid_o = valid_q;
  assign patch_o = patch_q;
  assign tag_o   = tag_q;
  assign path_o  = path_q;

endmodule

// File: rtl/kd_tree_search_pipe.sv
// KD-tree internal-node search: sequential node config load, then one query per
// cycle routed through LEVELS compare stages to a leaf index, with backpressure.
module kd_tree_search_pipe
  import kd_search_pkg::*;
#(
  parameter int DIM_WIDTH = KD_DIM_WIDTH,
  parameter int NUM_DIMS  = KD_NUM_DIMS,
  parameter int IDX_WIDTH = KD_IDX_WIDTH,
  parameter int LEVELS    = KD_LEVELS,
  parameter int TAG_WIDTH = KD_TAG_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_valid,
  input  logic [2*DIM_WIDTH-1:0]        cfg_data,
  input  logic                          cfg_restart,
  output logic                          cfg_done,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_DIMS*DIM_WIDTH-1:0] in_patch,
  input  logic [TAG_WIDTH-1:0]          in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LEVELS-1:0]             out_leaf,
  output logic [TAG_WIDTH-1:0]          out_tag,
  output logic [NUM_DIMS*DIM_WIDTH-1:0] out_patch,
  output logic                          err_bad_idx
);

  node_t                         node_q [NUM_NODES];
  logic [NUM_NODES*NODE_WIDTH-1:0] nodes_flat;

  logic [KD_LEVELS-1:0] wadr_q, wadr_d;
  logic                 cfg_done_q, cfg_done_d;
  logic                 err_q, err_d;
  logic                 cfg_we;
  logic                 stall;
  logic                 busy;

  logic [DIM_WIDTH-IDX_WIDTH-1:0] unused_cfg_bits;

  // Index 0 is the input register; index l+1 is the output of stage l.
  logic [KD_LEVELS:0]        valid_w;
  logic [PATCH_WIDTH-1:0]    patch_w [KD_LEVELS+1];
  logic [KD_TAG_WIDTH-1:0]   tag_w   [KD_LEVELS+1];
  logic [KD_LEVELS-1:0]      path_w  [KD_LEVELS+1];
  logic [KD_LEVELS-1:0]      bad_w;

  assign unused_cfg_bits = cfg_data[DIM_WIDTH-1:IDX_WIDTH];

  assign stall    = valid_w[KD_LEVELS] && !out_ready;
  assign busy     = |valid_w;
  assign in_ready = cfg_done_q && !stall && !cfg_restart;

  // Restart only takes effect on an empty pipeline, but always drops a same-cycle write.
  always_comb begin
    wadr_d     = wadr_q;
    cfg_done_d = cfg_done_q;
    cfg_we     = 1'b0;
    if (cfg_restart) begin
      if (!busy) begin
        wadr_d     = '0;
        cfg_done_d = 1'b0;
      end
    end else if (cfg_valid && !cfg_done_q) begin
      cfg_we = 1'b1;
      wadr_d = wadr_q + 1'b1;
      if (wadr_q == KD_LEVELS'(NUM_NODES - 1)) cfg_done_d = 1'b1;
    end
  end

  assign err_d = err_q || (!stall && |bad_w);

  always_ff @(posedge clk) begin
    if (rst) begin
      wadr_q     <= '0;
      cfg_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wadr_q     <= wadr_d;
      cfg_done_q <= cfg_done_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_we && !rst) begin
      node_q[wadr_q] <= {cfg_data[2*DIM_WIDTH-1:DIM_WIDTH], cfg_data[IDX_WIDTH-1:0]};
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_flat
      assign nodes_flat[gi*NODE_WIDTH +: NODE_WIDTH] = node_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_w[0] <= 1'b0;
      patch_w[0] <= '0;
      tag_w[0]   <= '0;
    end else if (!stall) begin
      valid_w[0] <= in_valid && in_ready;
      patch_w[0] <= in_patch;
      tag_w[0]   <= in_tag;
    end
  end

  assign path_w[0] = '0;

  generate
    for (genvar gi = 0; gi < KD_LEVELS; gi++) begin : g_stage
      kd_search_stage #(.LEVEL(gi)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .stall_i (stall),
        .nodes_i (nodes_flat),
        .valid_i (valid_w[gi]),
        .patch_i (patch_w[gi]),
        .tag_i   (tag_w[gi]),
        .path_i  (path_w[gi]),
        .valid_o (valid_w[gi+1]),
        .patch_o (patch_w[gi+1]),
        .tag_o   (tag_w[gi+1]),
        .path_o  (path_w[gi+1]),
        .bad_o   (bad_w[gi])
      );
    end
  endgenerate

  assign cfg_done    = cfg_done_q;
  assign err_bad_idx = err_q;
  assign out_valid   = valid_w[KD_LEVELS];
  assign out_leaf    = path_w[KD_LEVELS];
  assign out_tag     = tag_w[KD_LEVELS];
  assign out_patch   = patch_w[KD_LEVELS];

endmodule

// File: tb/tb_kd_tree_search_pipe.sv
// Directed and randomized checks of kd_tree_search_pipe against a heap-walk reference model.
module tb_kd_tree_search_pipe;

  localparam int DW = 11;
  localparam int ND = 5;
  localparam int LV = 6;
  localparam int TW = 8;
  localparam int NN = 63;
  localparam int PW = ND * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic [2*DW-1:0] cfg_data;
  logic          cfg_restart;
  logic          cfg_done;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_patch;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [LV-1:0] out_leaf;
  logic [TW-1:0] out_tag;
  logic [PW-1:0] out_patch;
  logic          err_bad_idx;

  kd_tree_search_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_data    (cfg_data),
    .cfg_restart (cfg_restart),
    .cfg_done    (cfg_done),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_patch    (in_patch),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_leaf    (out_leaf),
    .out_tag     (out_tag),
    .out_patch   (out_patch),
    .err_bad_idx (err_bad_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            leaf;
    logic [TW-1:0] tag;
    logic [PW-1:0] patch;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   tb_idx [NN];
  int   tb_med [NN];
  exp_t exp_q [$];
  int   cyc = 0;
  int   pops = 0;
  int   first_pop = 0;
  int   last_pop = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Reference: walk the heap from the root, child = 2n+1 (left) or 2n+2 (right).
  function automatic int model_leaf(input logic [PW-1:0] p);
    int n = 0;
    for (int l = 0; l < LV; l++) begin
      int d = tb_idx[n];
      int s = 0;
      logic signed [DW-1:0] c;
      if (d < ND) begin
        c = p[d*DW +: DW];
        s = c;
      end
      n = 2 * n + 1 + ((s >= tb_med[n]) ? 1 : 0);
    end
    return n - NN;
  endfunction

  function automatic logic [PW-1:0] rand_patch();
    logic [PW-1:0] p;
    logic signed [DW-1:0] c;
    for (int d = 0; d < ND; d++) begin
      c = DW'($urandom_range(0, 511));
      c = c - 11'sd256;
      p[d*DW +: DW] = c;
    end
    return p;
  endfunction

  function automatic logic [PW-1:0] fill_patch(input logic signed [DW-1:0] v);
    logic [PW-1:0] p;
    for (int d = 0; d < ND; d++) p[d*DW +: DW] = v;
    return p;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("output_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_leaf", 64'(out_leaf), 64'(e.leaf));
        chk("out_tag", 64'(out_tag), 64'(e.tag));
        chk("out_patch", 64'(out_patch), 64'(e.patch));
        pops++;
        if (pops == 1) first_pop = cyc;
        last_pop = cyc;
        $display("out tag=%02h leaf=%0d cycle=%0d", out_tag, out_leaf, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [PW-1:0] p, input logic [TW-1:0] t);
    in_valid = 1'b1;
    in_patch = p;
    in_tag   = t;
    for (int k = 0; k < 100; k++) begin
      #2;
      if (in_ready) begin
        exp_q.push_back('{model_leaf(p), t, p});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("send_accept", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    for (int k = 0; k < 60; k++) begin
      if (out_valid) break;
      tick();
    end
    chk("out_valid_seen", 64'(out_valid), 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  task automatic load_cfg();
    cfg_valid = 1'b1;
    for (int n = 0; n < NN; n++) begin
      cfg_data = {11'(tb_med[n]), 8'($urandom), 3'(tb_idx[n])};
      tick();
      if (n == NN - 2) chk("cfg_done_before_last", 64'(cfg_done), 64'd0);
    end
    cfg_valid = 1'b0;
    chk("cfg_done_after_last", 64'(cfg_done), 64'd1);
    chk("in_ready_after_cfg", 64'(in_ready), 64'd1);
  endtask

  task automatic restart(input logic with_write);
    cfg_restart = 1'b1;
    cfg_valid   = with_write;
    cfg_data    = 22'h3FFFFF;
    tick();
    cfg_restart = 1'b0;
    cfg_valid   = 1'b0;
    chk("restart_cfg_done", 64'(cfg_done), 64'd0);
    chk("restart_in_ready", 64'(in_ready), 64'd0);
  endtask

  task automatic flat_tree();
    for (int n = 0; n < NN; n++) begin
      tb_idx[n] = 0;
      tb_med[n] = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int start;

    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_data = '0;
    cfg_restart = 1'b0;
    in_valid = 1'b0;
    in_patch = '0;
    in_tag = '0;
    out_ready = 1'b1;
    repeat (3) tick();

    chk("rst_cfg_done", 64'(cfg_done), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_leaf", 64'(out_leaf), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_patch", 64'(out_patch), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_err", 64'(err_bad_idx), 64'd0);
    rst = 1'b0;
    tick();

    // Config load, then an extra write that must be ignored
    flat_tree();
    load_cfg();
    cfg_valid = 1'b1;
    cfg_data  = {11'sd7, 8'h00, 3'd1};
    tick();
    cfg_valid = 1'b0;
    chk("extra_write_cfg_done", 64'(cfg_done), 64'd1);
    chk("extra_write_in_ready", 64'(in_ready), 64'd1);

    // Basic routing and latency
    send(fill_patch(-11'sd1), 8'h11);
    chk("accept_no_early_out", 64'(out_valid), 64'd0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk("latency", 64'(lat), 64'(LV));
    chk("leaf_leftmost", 64'(out_leaf), 64'd0);
    drain();
    send(fill_patch(11'sd0), 8'h22);
    wait_out();
    chk("leaf_rightmost", 64'(out_leaf), 64'd63);
    drain();

    // Back-to-back throughput
    pops = 0;
    start = cyc;
    for (int i = 0; i < 10; i++) send(rand_patch(), 8'(8'h30 + i));
    chk("burst_accept_cycles", 64'(cyc - start), 64'd10);
    drain();
    chk("burst_pops", 64'(pops), 64'd10);
    chk("burst_consecutive", 64'(last_pop - first_pop), 64'd9);

    // Mixed split: root on dim1
    restart(1'b1);
    flat_tree();
    tb_idx[0] = 1;
    tb_med[0] = 100;
    load_cfg();
    begin
      logic [PW-1:0] p;
      p = '0;
      p[0*DW +: DW] = -11'sd5;
      p[1*DW +: DW] = 11'sd100;
      send(p, 8'h44);
    end
    wait_out();
    chk("mixed_leaf", 64'(out_leaf), 64'd32);
    drain();

    // Random tree, random queries, random downstream readiness
    restart(1'b0);
    for (int n = 0; n < NN; n++) begin
      tb_idx[n] = int'($urandom_range(0, ND - 1));
      tb_med[n] = int'($urandom_range(0, 400)) - 200;
    end
    load_cfg();
    fork
      for (int i = 0; i < 40; i++) send(rand_patch(), 8'($urandom));
      begin
        repeat (70) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Backpressure: 4-cycle stall right after first output
    pops = 0;
    fork
      for (int i = 0; i < 8; i++) send(rand_patch(), 8'(8'h80 + i));
      begin
        for (int k = 0; k < 60; k++) begin
          if (out_valid) break;
          tick();
        end
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          tick();
          chk("bp_in_ready_low", 64'(in_ready), 64'd0);
          chk("bp_out_valid_held", 64'(out_valid), 64'd1);
          chk("bp_tag_held", 64'(out_tag), 64'(exp_q[0].tag));
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_pops", 64'(pops), 64'd8);

    // Out-of-range split index at the root
    restart(1'b0);
    flat_tree();
    tb_idx[0] = 5;
    load_cfg();
    chk("err_clear_before", 64'(err_bad_idx), 64'd0);
    send(fill_patch(-11'sd1), 8'h66);
    wait_out();
    chk("bad_idx_leaf", 64'(out_leaf), 64'd32);
    chk("err_set", 64'(err_bad_idx), 64'd1);
    drain();
    restart(1'b0);
    for (int n = 0; n < NN; n++) begin
      tb_idx[n] = int'($urandom_range(0, 7));
      tb_med[n] = int'($urandom_range(0, 200)) - 100;
    end
    load_cfg();
    for (int i = 0; i < 12; i++) send(rand_patch(), 8'($urandom));
    drain();
    repeat (5) tick();
    chk("err_sticky", 64'(err_bad_idx), 64'd1);

    // Reset clears error and config
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_err", 64'(err_bad_idx), 64'd0);
    chk("rst2_cfg_done", 64'(cfg_done), 64'd0);
    load_cfg();

    // Restart while queries are in flight is ignored
    for (int i = 0; i < 3; i++) send(rand_patch(), 8'(8'hA0 + i));
    cfg_restart = 1'b1;
    #2;
    chk("restart_busy_in_ready", 64'(in_ready), 64'd0);
    tick();
    cfg_restart = 1'b0;
    chk("restart_busy_ignored", 64'(cfg_done), 64'd1);
    drain();
    restart(1'b0);
    load_cfg();

    // Reset mid-stream discards in-flight queries
    for (int i = 0; i < 5; i++) send(rand_patch(), 8'(8'hC0 + i));
    rst = 1'b1;
    tick();
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_cfg_done", 64'(cfg_done), 64'd0);
    exp_q.delete();
    rst = 1'b0;
    repeat (8) tick();
    chk("midrst_no_output", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
